rd_burst_arbiter: RTL and testbench
===================================

# rd_burst_arbiter

Read-side burst arbiter for the asynchronous FIFO: shares the single FIFO read port, clocked on `rd_clk`, between `N` consumers. Each consumer requests a burst of 1..2^LW words. The arbiter grants consumers in round-robin order. It issues `fifo_rd_en` only while the FIFO is non-empty and steers each returned word to the granted consumer with a per-consumer valid strobe. It sits between the read logic/memory of the FIFO and the downstream consumers.

## Interface
- `N`, 4: number of requesters, 2..8.
- `DW`, 8: FIFO data width.
- `LW`, 4: burst length field width. A length code `L` means `L+1` words.
- `rd_clk  in  1`: read-domain clock. Only clock.
- `rd_rst  in  1`: reset, synchronous, active-high.
- `fifo_empty  in  1`: FIFO empty flag, already in the `rd_clk` domain.
- `fifo_rd_data  in  DW`: FIFO read data, valid the cycle after a pop.
- `fifo_rd_en  out  1`: pop request. Never asserted while `fifo_empty`=1.
- `req  in  N`: per-consumer burst request, level.
- `req_len  in  N*LW`: per-consumer length code. Slice `i` is `[i*LW +: LW]`.
- `gnt  out  N`: one-hot grant, held for the whole burst.
- `out_data  out  DW`: returned word, shared by all consumers.
- `out_valid  out  N`: one-hot; bit `g` marks `out_data` valid for consumer `g`.
- `burst_done  out  N`: one-cycle pulse on the last word of a burst.
- `busy  out  1`: high in any state other than IDLE.

## Operation
- FSM states are IDLE, BURST and DRAIN. Encoding is binary, 2 bits.
- IDLE:
  - If `req` != 0, pick the first set bit at or after `rr_ptr`, wrapping modulo N.
  - Latch its index `g` and its `req_len` into `remaining` (LW+1 bits, loaded with L+1).
  - Set `gnt` = onehot(g) and go to BURST.
- BURST:
  - `fifo_rd_en` = ~`fifo_empty` & (`remaining` != 0). This is combinational from state and registers.
  - Each pop decrements `remaining`.
  - When the pop makes `remaining` reach 0, go to DRAIN.
  - An empty FIFO stalls the burst indefinitely. There is no timeout.
- DRAIN:
  - One cycle; the last word is returned here.
  - Clear `gnt`, set `rr_ptr` = (g+1) mod N, go to IDLE.
- Return path:
  - `out_valid` is a registered copy of (pop ? onehot(g) : 0).
  - `out_data` is `fifo_rd_data` passed through unregistered.
  - `burst_done[g]` pulses together with the `out_valid[g]` of the final word.
- Consumers have no backpressure and must accept every `out_valid` strobe.
- `req` and `req_len` are sampled only in IDLE. Changes during BURST or DRAIN, including dropping `req`, are ignored and the burst completes.
- `rr_ptr` updates only on burst completion. This gives strict rotation, so no consumer starves.

## Timing
- Reset value of every output is 0 at the first `rd_clk` edge with `rd_rst`=1: `gnt`, `out_valid`, `burst_done`, `fifo_rd_en`, `busy`.
- Internal reset values: `rr_ptr`=0, state IDLE, `remaining`=0.
- Reset mid-burst aborts immediately. A word already popped but not yet returned is dropped (no `out_valid`). This loss is accepted.
- Latency from `req` rising (in IDLE) to `gnt` is 1 cycle.
- The first `fifo_rd_en` is in the cycle `gnt` rises, if the FIFO is non-empty.
- Pop-to-`out_valid` latency is 1 cycle. Throughput is 1 word per cycle with a non-empty FIFO.
- An L+1 word burst on a never-empty FIFO:
  - `gnt` is high for L+2 cycles, then 1 IDLE cycle.
  - Minimum gap between bursts is therefore 1 cycle of `gnt` low.
- `fifo_empty` rising mid-burst gates `fifo_rd_en` low in the same cycle, with no extra pop.
- Wrap-around: with `rr_ptr`=N-1 and `req`=onehot(0) | onehot(N-1), requester N-1 wins.
- Length code all-ones gives 2^LW words. `remaining` is LW+1 bits so it cannot overflow.

## Structure
- Shared package `fifo_pkg` holds:
  - the FSM state typedef (IDLE, BURST, DRAIN);
  - the default `DW`/`LW` constants, shared with the FIFO.
- One sub-module, `rr_pick`: combinational round-robin picker. Inputs are `req[N]` and `rr_ptr`; outputs are `valid` and `idx`. It is reusable by the write-side arbiter.
- Everything else (FSM, counter, return-path register) stays in `rd_burst_arbiter`.

## Test plan
- Reset mid-burst:
  - Stimulus: assert `rd_rst` during the 2nd word of a 4-word burst.
  - Response: next edge has all outputs 0; no further `out_valid`; after release the next grant goes to requester 0.
- Single requester:
  - Stimulus: `req`=0001, `len`=3, FIFO holds A0..A3.
  - Response: `gnt`=0001 for 5 cycles; `out_valid`=0001 on 4 consecutive cycles carrying A0..A3; `burst_done[0]` on A3.
- Round-robin rotation:
  - Stimulus: `req`=1111 held, all `len`=0.
  - Response: grants go 0,1,2,3,0 with one IDLE cycle between grants.
- Empty stall:
  - Stimulus: 4-word burst, FIFO empty after 2 words for 5 cycles, then refilled.
  - Response: `fifo_rd_en` low while empty; exactly 4 pops total; `gnt` held throughout.
- Wrap and max length:
  - Stimulus: `rr_ptr`=3, `req`=1001, `len`=15.
  - Response: requester 3 receives 16 words; then requester 0 is granted.
- Request drop:
  - Stimulus: requester 2 deasserts `req` mid-burst.
  - Response: burst still completes with its full word count.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg : shared FIFO constants and read-arbiter FSM state type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int FIFO_DW = 8;
  localparam int FIFO_LW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin picker (first request at/after rr_ptr)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  // Scan offsets from the far end down so the nearest requester wins last.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % N]) begin
        idx = PW'((int'(rr_ptr) + k) % N);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rd_burst_arbiter.sv
// ---------------------------------------------------------------------------
// rd_burst_arbiter : round-robin burst arbiter sharing the FIFO read port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rd_burst_arbiter
  import fifo_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = FIFO_DW,
  parameter int LW = FIFO_LW
) (
  input  logic            rd_clk,
  input  logic            rd_rst,
  input  logic            fifo_empty,
  input  logic [DW-1:0]   fifo_rd_data,
  output logic            fifo_rd_en,
  input  logic [N-1:0]    req,
  input  logic [N*LW-1:0] req_len,
  output logic [N-1:0]    gnt,
  output logic [DW-1:0]   out_data,
  output logic [N-1:0]    out_valid,
  output logic [N-1:0]    burst_done,
  output logic            busy
);

  localparam int            PW          = $clog2(N);
  localparam logic [N-1:0]  ONE_HOT_LSB = N'(1);
  localparam logic [PW-1:0] LAST_IDX    = PW'(N - 1);

  rd_state_t       r_state;
  logic [PW-1:0]   r_gidx;
  logic [PW-1:0]   r_rr_ptr;
  logic [LW:0]     r_remaining;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    r_out_valid;
  logic [N-1:0]    r_burst_done;

  logic            w_pick_valid;
  logic [PW-1:0]   w_pick_idx;
  logic            w_pop;
  logic            w_last;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .valid  (w_pick_valid),
    .idx    (w_pick_idx)
  );

  assign w_pop  = (r_state == ST_BURST) && !fifo_empty && (r_remaining != '0);
  assign w_last = w_pop && (r_remaining == (LW + 1)'(1));

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state      <= ST_IDLE;
      r_gidx       <= '0;
      r_rr_ptr     <= '0;
      r_remaining  <= '0;
      r_gnt        <= '0;
      r_out_valid  <= '0;
      r_burst_done <= '0;
    end else begin
      // Return strobes trail the pop by one cycle, matching FIFO read latency.
      r_out_valid  <= w_pop  ? (ONE_HOT_LSB << r_gidx) : '0;
      r_burst_done <= w_last ? (ONE_HOT_LSB << r_gidx) : '0;

      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_gidx      <= w_pick_idx;
            r_remaining <= {1'b0, req_len[w_pick_idx*LW +: LW]} + 1'b1;
            r_gnt       <= ONE_HOT_LSB << w_pick_idx;
            r_state     <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_pop) begin
            r_remaining <= r_remaining - 1'b1;
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_gnt    <= '0;
          r_rr_ptr <= (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en = w_pop;
  assign gnt        = r_gnt;
  assign out_data   = fifo_rd_data;
  assign out_valid  = r_out_valid;
  assign burst_done = r_burst_done;
  assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rd_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rd_burst_arbiter : scoreboard bench for rd_burst_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rd_burst_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LW = 4;

  logic            rd_clk       = 1'b0;
  logic            rd_rst       = 1'b1;
  logic            fifo_empty   = 1'b1;
  logic [DW-1:0]   fifo_rd_data = '0;
  logic            fifo_rd_en;
  logic [N-1:0]    req          = '0;
  logic [N*LW-1:0] req_len      = '0;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   out_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    burst_done;
  logic            busy;

  typedef struct {
    logic [N-1:0]  v;
    logic [DW-1:0] d;
    logic [N-1:0]  done;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] fq[$];
  exp_t          mon_e;
  int            n_assert = 0;
  int            n_fail   = 0;
  int            npops    = 0;
  bit            mon_en   = 1'b0;

  rd_burst_arbiter #(
    .N  (N),
    .DW (DW),
    .LW (LW)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .req          (req),
    .req_len      (req_len),
    .gnt          (gnt),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .burst_done   (burst_done),
    .busy         (busy)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Behavioural FIFO: data appears the cycle after a pop.
  always @(posedge rd_clk) begin
    if (fifo_rd_en === 1'b1) begin
      if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
      npops++;
    end
    #1 fifo_empty = (fq.size() == 0);
  end

  task automatic fifo_push(input logic [DW-1:0] d);
    fq.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic load(input int who, input logic [DW-1:0] d, input bit last);
    exp_t e;
    e.v    = N'(1) << who;
    e.d    = d;
    e.done = last ? (N'(1) << who) : '0;
    fifo_push(d);
    sb.push_back(e);
  endtask

  task automatic set_len(input int who, input logic [LW-1:0] l);
    req_len[who*LW +: LW] = l;
  endtask

  // Called on a negedge with gnt low; returns on the first negedge with gnt high.
  task automatic wait_rise(input string tag, output int lo);
    lo = 1;
    while (lo < 300) begin
      @(negedge rd_clk);
      if (gnt !== '0) return;
      lo++;
    end
    check({tag, "_rise_timeout"}, 32'd1, 32'd0);
  endtask

  // Called on a negedge with gnt high; returns on the first negedge with gnt low.
  task automatic wait_fall(input string tag, output int hi);
    hi = 1;
    while (hi < 300) begin
      @(negedge rd_clk);
      if (gnt === '0) return;
      hi++;
    end
    check({tag, "_fall_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic settle(input string tag);
    repeat (3) @(negedge rd_clk);
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"},        32'(gnt),        32'd0);
    check({tag, "_out_valid"},  32'(out_valid),  32'd0);
    check({tag, "_burst_done"}, 32'(burst_done), 32'd0);
    check({tag, "_fifo_rd_en"}, 32'(fifo_rd_en), 32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_rst = 1'b1;
    repeat (2) @(negedge rd_clk);
    fq.delete();
    sb.delete();
    fifo_empty = 1'b1;
    req        = '0;
    req_len    = '0;
    npops      = 0;
    rd_rst     = 1'b0;
  endtask

  always @(negedge rd_clk) begin
    if (mon_en) begin
      check("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
      if (out_valid !== '0 || burst_done !== '0) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {24'd0, out_valid, burst_done}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("out_valid",  32'(out_valid),  32'(mon_e.v));
          check("out_data",   32'(out_data),   32'(mon_e.d));
          check("burst_done", 32'(burst_done), 32'(mon_e.done));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo;
    int hi;

    // Reset values
    @(posedge rd_clk);
    #1;
    check_outputs_zero("reset");
    @(negedge rd_clk);
    rd_rst = 1'b0;
    mon_en = 1'b1;

    // Single requester, 4 words
    for (int k = 0; k < 4; k++) load(0, DW'(8'hA0 + k), k == 3);
    set_len(0, 4'd3);
    req = 4'b0001;
    wait_rise("single", lo);
    req = '0;
    check("single_req_to_gnt", 32'(lo), 32'd1);
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_first_pop", 32'(fifo_rd_en), 32'd1);
    wait_fall("single", hi);
    check("single_gnt_cycles", 32'(hi), 32'd5);
    settle("single");

    // Round-robin rotation with all requesters held
    do_reset();
    for (int k = 0; k < 5; k++) load(k % N, DW'(8'h10 + k), 1'b1);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_rise("rr", lo);
      check("rr_gnt", 32'(gnt), 32'(1 << (k % N)));
      if (k > 0) check("rr_idle_gap", 32'(lo), 32'd1);
      if (k == 4) req = '0;
      wait_fall("rr", hi);
      check("rr_gnt_cycles", 32'(hi), 32'd2);
    end
    settle("rr");

    // Empty stall: two words available, then a 5-cycle starvation
    npops = 0;
    load(1, 8'hB0, 1'b0);
    load(1, 8'hB1, 1'b0);
    set_len(1, 4'd3);
    req = 4'b0010;
    wait_rise("stall", lo);
    req = '0;
    check("stall_gnt", 32'(gnt), 32'h2);
    lo = 0;
    while (npops < 2 && lo < 50) begin
      @(negedge rd_clk);
      lo++;
    end
    check("stall_two_pops", 32'(npops), 32'd2);
    for (int k = 0; k < 5; k++) begin
      check("stall_rd_en_low", 32'(fifo_rd_en), 32'd0);
      check("stall_gnt_held", 32'(gnt), 32'h2);
      @(negedge rd_clk);
    end
    begin
      exp_t e;
      e.v = 4'b0010; e.d = 8'hB2; e.done = '0;
      sb.push_back(e);
      e.d = 8'hB3; e.done = 4'b0010;
      sb.push_back(e);
    end
    fifo_push(8'hB2);
    fifo_push(8'hB3);
    wait_fall("stall", hi);
    check("stall_total_pops", 32'(npops), 32'd4);
    settle("stall");

    // Request dropped mid-burst still completes 6 words
    for (int k = 0; k < 6; k++) load(2, DW'(8'hC0 + k), k == 5);
    set_len(2, 4'd5);
    req = 4'b0100;
    wait_rise("drop", lo);
    check("drop_gnt", 32'(gnt), 32'h4);
    repeat (2) @(negedge rd_clk);
    req = '0;
    wait_fall("drop", hi);
    check("drop_gnt_cycles", 32'(hi + 2), 32'd7);
    settle("drop");

    // Wrap from rr_ptr=3 with maximum length, then requester 0
    for (int k = 0; k < 16; k++) load(3, DW'(8'h40 + k), k == 15);
    for (int k = 0; k < 3; k++) load(0, DW'(8'h70 + k), k == 2);
    set_len(3, 4'hF);
    set_len(0, 4'd2);
    req = 4'b1001;
    wait_rise("wrap", lo);
    check("wrap_gnt_first", 32'(gnt), 32'h8);
    wait_fall("wrap", hi);
    check("wrap_max_gnt_cycles", 32'(hi), 32'd17);
    wait_rise("wrap2", lo);
    req = '0;
    check("wrap_gnt_second", 32'(gnt), 32'h1);
    check("wrap_idle_gap", 32'(lo), 32'd1);
    wait_fall("wrap2", hi);
    check("wrap_second_gnt_cycles", 32'(hi), 32'd4);
    settle("wrap");

    // Reset during the second word of a 4-word burst
    load(2, 8'hD0, 1'b0);
    fifo_push(8'hD1);
    fifo_push(8'hD2);
    fifo_push(8'hD3);
    set_len(2, 4'd3);
    req = 4'b0100;
    wait_rise("rst_mid", lo);
    req = '0;
    check("rst_mid_gnt", 32'(gnt), 32'h4);
    @(negedge rd_clk);
    rd_rst = 1'b1;
    @(negedge rd_clk);
    check_outputs_zero("rst_mid");
    rd_rst = 1'b0;
    begin
      exp_t e;
      e.v = 4'b0001; e.d = 8'hD2; e.done = 4'b0001;
      sb.push_back(e);
    end
    set_len(0, 4'd0);
    req = 4'b0101;
    wait_rise("rst_after", lo);
    req = '0;
    check("rst_after_gnt", 32'(gnt), 32'h1);
    wait_fall("rst_after", hi);
    check("rst_after_gnt_cycles", 32'(hi), 32'd2);
    settle("rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
